// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline elastic stages: state encodings and
// the MEM->WB payload width.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_t;

  // Payload = ALU result + load data + destination + RegWrite + MemtoReg
  function automatic int mem_wb_payload_width(input int data_w, input int addr_w);
    return 2 * data_w + addr_w + 2;
  endfunction

  localparam int MEM_WB_PAYLOAD_W = mem_wb_payload_width(32, 5);

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry elastic buffer: main register drives the output, skid register
// absorbs the beat accepted while the consumer stalls. Flush empties both.
module pipe_skid_buffer
  import mips_pipe_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 8
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [PAYLOAD_WIDTH-1:0] i_payload,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [PAYLOAD_WIDTH-1:0] o_payload
);

  skid_state_t              state_r, state_nxt_s;
  logic [PAYLOAD_WIDTH-1:0] main_r, skid_r;
  logic                     in_xfer_s, out_xfer_s;
  logic                     load_main_in_s, load_main_skid_s, load_skid_s;

  // Ready and valid decode registered state only, so no combinational path crosses the stage
  assign o_ready    = (state_r != ST_FULL);
  assign o_valid    = (state_r != ST_EMPTY);
  assign o_payload  = main_r;
  assign in_xfer_s  = i_valid & o_ready;
  assign out_xfer_s = o_valid & i_ready;

  // Next-state and register-load decode; flush overrides every transfer
  always_comb begin
    state_nxt_s      = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (i_flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_nxt_s    = ST_ONE;
            load_main_in_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            state_nxt_s    = ST_ONE;
            load_main_in_s = 1'b1;
          end else if (in_xfer_s) begin
            state_nxt_s = ST_FULL;
            load_skid_s = 1'b1;
          end else if (out_xfer_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            state_nxt_s      = ST_ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) state_r <= ST_EMPTY;
    else        state_r <= state_nxt_s;
  end

  // Payload registers hold unless explicitly loaded
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      main_r <= {PAYLOAD_WIDTH{1'b0}};
      skid_r <= {PAYLOAD_WIDTH{1'b0}};
    end else begin
      if (load_main_in_s)        main_r <= i_payload;
      else if (load_main_skid_s) main_r <= skid_r;
      if (load_skid_s)           skid_r <= i_payload;
    end
  end

endmodule

// File: rtl/mem_wb_elastic_reg.sv
// MEM->WB elastic pipeline register: skid-buffered payload, valid-qualified
// RegWrite, WB result mux and a saturating bubble counter.
module mem_wb_elastic_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_ValidM,
  output logic                     o_ReadyM,
  input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
  input  logic [DATA_WIDTH-1:0]    i_ReadDataM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic                     i_RegWriteM,
  input  logic                     i_MemtoRegM,
  input  logic                     i_FlushW,
  output logic                     o_ValidW,
  input  logic                     i_ReadyW,
  output logic [DATA_WIDTH-1:0]    o_ALUOutW,
  output logic [DATA_WIDTH-1:0]    o_ReadDataW,
  output logic [RF_ADDR_WIDTH-1:0] o_WriteRegW,
  output logic                     o_RegWriteW,
  output logic                     o_MemtoRegW,
  output logic [DATA_WIDTH-1:0]    o_ResultW,
  input  logic                     i_CntClr,
  output logic [CNT_WIDTH-1:0]     o_BubbleCnt
);

  localparam int PW = mem_wb_payload_width(DATA_WIDTH, RF_ADDR_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [PW-1:0]        in_payload_s, out_payload_s;
  logic                 valid_s, regwrite_s;
  logic [CNT_WIDTH-1:0] cnt_r;

  assign in_payload_s = {i_ALUOutM, i_ReadDataM, i_WriteRegM, i_RegWriteM, i_MemtoRegM};

  pipe_skid_buffer #(
    .PAYLOAD_WIDTH(PW)
  ) u_skid (
    .i_CLK     (i_CLK),
    .i_RST     (i_RST),
    .i_flush   (i_FlushW),
    .i_valid   (i_ValidM),
    .o_ready   (o_ReadyM),
    .i_payload (in_payload_s),
    .o_valid   (valid_s),
    .i_ready   (i_ReadyW),
    .o_payload (out_payload_s)
  );

  assign {o_ALUOutW, o_ReadDataW, o_WriteRegW, regwrite_s, o_MemtoRegW} = out_payload_s;
  // A stale payload after flush must never reach the register file
  assign o_RegWriteW = regwrite_s & valid_s;
  assign o_ValidW    = valid_s;
  assign o_ResultW   = o_MemtoRegW ? o_ReadDataW : o_ALUOutW;
  assign o_BubbleCnt = cnt_r;

  // Saturating bubble counter; clear wins over counting, flush leaves it alone
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST)                          cnt_r <= {CNT_WIDTH{1'b0}};
    else if (i_CntClr)                   cnt_r <= {CNT_WIDTH{1'b0}};
    else if (!valid_s && cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_ONE;
    else                                 cnt_r <= cnt_r;
  end

endmodule
